regfile_scoreboard: RTL

REGFILE_SCOREBOARD -- requirements
Module: regfile_scoreboard

---
 rtl/regfile_pkg.sv | 10 +
 rtl/regfile_scoreboard_pend_counter.sv | 24 ++
 rtl/regfile_scoreboard.sv | 76 +++++++
 3 files changed

// File: rtl/regfile_pkg.sv
// regfile_pkg: shared sizing defaults and helpers for the register file scoreboard
package regfile_pkg;
  localparam int DATA_W_DEF = 32;
  localparam int NUM_REGS_DEF = 32;
  localparam int PEND_W_DEF = 2;
  localparam int ZERO_REG = 0;
  function automatic int addr_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction
endpackage

// File: rtl/regfile_scoreboard_pend_counter.sv
// pend_counter: per-register outstanding-write counter with saturation and underflow detect
module pend_counter #(
  parameter int PEND_W = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              inc,
  input  logic              dec,
  output logic [PEND_W-1:0] cnt,
  output logic              underflow
);
  localparam logic [PEND_W-1:0] MAX = '1;
  logic [PEND_W-1:0] cnt_d, cnt_q;
  always_comb begin
    cnt_d = (inc && !dec && cnt_q != MAX) ? cnt_q + 1'b1 :
            (dec && !inc && cnt_q != '0)  ? cnt_q - 1'b1 : cnt_q;
  end
  always_ff @(posedge clk) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end
  assign cnt = cnt_q;
  assign underflow = dec && !inc && cnt_q == '0;
endmodule

// File: rtl/regfile_scoreboard.sv
// regfile_scoreboard: flop-based register file with write-first reads and pending-write hazard tracking
module regfile_scoreboard import regfile_pkg::*; #(
  parameter int DATA_W = DATA_W_DEF,
  parameter int NUM_REGS = NUM_REGS_DEF,
  parameter int PEND_W = PEND_W_DEF,
  localparam int ADDR_W = addr_w(NUM_REGS)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] idRs,
  input  logic [ADDR_W-1:0] idRt,
  output logic [DATA_W-1:0] idregA,
  output logic [DATA_W-1:0] idregB,
  input  logic              idIssue,
  input  logic [ADDR_W-1:0] idDest,
  output logic              idHazard,
  input  logic              WBregWrite,
  input  logic [ADDR_W-1:0] WBwriteReg,
  input  logic [DATA_W-1:0] WBresult,
  output logic              sbErr,
  output logic              pendAny
);
  localparam int DEPTH = 2**ADDR_W;
  localparam logic [PEND_W-1:0] PEND_MAX = '1;
  localparam logic [PEND_W-1:0] PEND_ONE = PEND_W'(1);
  logic [DEPTH-1:0] valid, underflow, nonzero;
  logic [PEND_W-1:0] pend [DEPTH];
  logic [DATA_W-1:0] regs_q [DEPTH];
  logic [DATA_W-1:0] regs_d [DEPTH];
  logic sb_err_q, sb_err_d;
  logic wb_en, haz_rs, haz_rt, haz_dest, issue_ok;
  assign wb_en = WBregWrite && valid[WBwriteReg];
  // a source clears its hazard when this cycle's writeback retires its last pending write
  assign haz_rs = valid[idRs] && pend[idRs] != '0 &&
                  !(wb_en && WBwriteReg == idRs && pend[idRs] == PEND_ONE);
  assign haz_rt = valid[idRt] && pend[idRt] != '0 &&
                  !(wb_en && WBwriteReg == idRt && pend[idRt] == PEND_ONE);
  assign haz_dest = idIssue && valid[idDest] && pend[idDest] == PEND_MAX;
  assign idHazard = haz_rs || haz_rt || haz_dest;
  assign issue_ok = idIssue && !idHazard && valid[idDest];
  assign idregA = !valid[idRs] ? '0 : (wb_en && WBwriteReg == idRs) ? WBresult : regs_q[idRs];
  assign idregB = !valid[idRt] ? '0 : (wb_en && WBwriteReg == idRt) ? WBresult : regs_q[idRt];
  for (genvar i = 0; i < DEPTH; i++) begin : g_reg
    assign valid[i] = (i != ZERO_REG) && (i < NUM_REGS);
    assign nonzero[i] = pend[i] != '0;
    if (i != ZERO_REG && i < NUM_REGS) begin : g_cnt
      pend_counter #(.PEND_W(PEND_W)) u_cnt (
        .clk       (clk),
        .rst       (rst),
        .inc       (issue_ok && idDest == ADDR_W'(i)),
        .dec       (wb_en && WBwriteReg == ADDR_W'(i)),
        .cnt       (pend[i]),
        .underflow (underflow[i])
      );
    end else begin : g_none
      assign pend[i] = '0;
      assign underflow[i] = 1'b0;
    end
  end
  always_comb begin
    for (int r = 0; r < DEPTH; r++)
      regs_d[r] = (wb_en && WBwriteReg == ADDR_W'(r)) ? WBresult : regs_q[r];
    sb_err_d = sb_err_q || (|underflow);
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int r = 0; r < DEPTH; r++) regs_q[r] <= '0;
      sb_err_q <= 1'b0;
    end else begin
      regs_q <= regs_d;
      sb_err_q <= sb_err_d;
    end
  end
  assign sbErr = sb_err_q;
  assign pendAny = |nonzero;
endmodule
